// File: rtl/btn_conditioner.sv
// Per-button synchroniser, debouncer and press/auto-repeat pulse generator.
// Each channel runs its own IDLE/HELD/REPEAT/RELEASE machine on the synchronised level.
module btn_conditioner #(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned CNT_W           = 24,
  parameter int unsigned DEBOUNCE_CYCLES = 512,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 5_000_000,
  parameter int unsigned REPEAT_PERIOD   = 2_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [NUM_BTN-1:0] btn_level
);

  typedef enum logic [1:0] {IDLE, HELD, REPEAT, RELEASE} state_t;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] s;

  // NOTE: non-blocking assignments let both synchroniser stages update from the
  // values of the previous edge, giving a true two-flop pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= btn_raw;
      s     <= sync1;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (!s[i]) begin
            cnt_d = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = HELD;
            pulse_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        HELD: begin
          if (!s[i]) begin
            state_d = RELEASE;
            cnt_d   = '0;
          end else if (REPEAT_EN && cnt_q == RD_LAST) begin
            state_d = REPEAT;
            pulse_d = 1'b1;
            cnt_d   = '0;
          end else if (cnt_q != RD_LAST) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        REPEAT: begin
          if (!s[i]) begin
            state_d = RELEASE;
            cnt_d   = '0;
          end else if (cnt_q == RP_LAST) begin
            pulse_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        RELEASE: begin
          // A return to high here is a release bounce: resume holding, no new press.
          if (s[i]) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // NOTE: the per-channel counter is reset along with the state, so a reset
    // mid-count always restarts a full debounce period.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pulse_q <= pulse_d;
      end
    end

    assign btn_pulse[i] = pulse_q;
    assign btn_level[i] = (state_q != IDLE);
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: scripted table, directed corner sequences and a
// randomized phase checked against a run-length model of the button rules.
module tb_btn_conditioner;
  localparam int NB = 4;
  localparam int D  = 8;
  localparam int RD = 20;
  localparam int RP = 5;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] pulse_a, level_a, pulse_b, level_b;

  btn_conditioner #(
    .NUM_BTN(NB), .CNT_W(8), .DEBOUNCE_CYCLES(D), .REPEAT_EN(1'b1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_a (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .btn_pulse(pulse_a), .btn_level(level_a)
  );

  btn_conditioner #(
    .NUM_BTN(NB), .CNT_W(8), .DEBOUNCE_CYCLES(D), .REPEAT_EN(1'b0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_b (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .btn_pulse(pulse_b), .btn_level(level_b)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: press after D consecutive high samples, release after D+1
  // consecutive low samples, repeats at RD, RD+RP, ... edges after the press
  // or after the first high sample that ends a release bounce.
  logic [NB-1:0] m_r1 = '0, m_r2 = '0;
  int            m_ones [2][NB];
  int            m_zeros[2][NB];
  int            m_age  [2][NB];
  bit            m_lvl  [2][NB];
  logic [NB-1:0] m_pulse[2];

  initial begin
    for (int v = 0; v < 2; v++) begin
      m_pulse[v] = '0;
      for (int c = 0; c < NB; c++) begin
        m_ones[v][c] = 0; m_zeros[v][c] = 0; m_age[v][c] = 0; m_lvl[v][c] = 1'b0;
      end
    end
  end

  task automatic model_edge();
    logic [NB-1:0] s_now;
    if (reset) begin
      m_r1 = '0;
      m_r2 = '0;
      for (int v = 0; v < 2; v++) begin
        m_pulse[v] = '0;
        for (int c = 0; c < NB; c++) begin
          m_ones[v][c] = 0; m_zeros[v][c] = 0; m_age[v][c] = 0; m_lvl[v][c] = 1'b0;
        end
      end
    end else begin
      s_now = m_r2;
      m_r2  = m_r1;
      m_r1  = btn_raw;
      for (int v = 0; v < 2; v++) begin
        for (int c = 0; c < NB; c++) begin
          m_pulse[v][c] = 1'b0;
          if (s_now[c]) begin m_ones[v][c]++; m_zeros[v][c] = 0; end
          else          begin m_zeros[v][c]++; m_ones[v][c] = 0; end
          if (!m_lvl[v][c]) begin
            if (m_ones[v][c] == D) begin
              m_pulse[v][c] = 1'b1; m_lvl[v][c] = 1'b1; m_age[v][c] = 0;
            end
          end else if (!s_now[c]) begin
            if (m_zeros[v][c] == D + 1) m_lvl[v][c] = 1'b0;
          end else if (m_ones[v][c] == 1) begin
            m_age[v][c] = 0;
          end else begin
            m_age[v][c]++;
            if (v == 0 && m_age[v][c] >= RD && (m_age[v][c] - RD) % RP == 0)
              m_pulse[v][c] = 1'b1;
          end
        end
      end
    end
  endtask

  always @(posedge clk) model_edge();

  always @(negedge clk) begin
    logic [NB-1:0] la, lb;
    for (int c = 0; c < NB; c++) begin
      la[c] = m_lvl[0][c];
      lb[c] = m_lvl[1][c];
    end
    check("model_pulse_rep", pulse_a, m_pulse[0]);
    check("model_level_rep", level_a, la);
    check("model_pulse_norep", pulse_b, m_pulse[1]);
    check("model_level_norep", level_b, lb);
  end

  typedef struct {
    logic          rst;
    logic [NB-1:0] raw;
    int            cycles;
    logic [NB-1:0] exp_pulse;
    logic [NB-1:0] exp_level;
  } step_t;

  step_t tbl [13];

  initial begin
    int first, na, nb;

    // Clean press on channel 0; edge 0 is the first edge sampling raw high.
    tbl[0]  = '{1'b1, 4'h0, 2,  4'h0, 4'h0};   // reset state
    tbl[1]  = '{1'b0, 4'h0, 3,  4'h0, 4'h0};
    tbl[2]  = '{1'b0, 4'h1, 9,  4'h0, 4'h0};   // edges 0..8
    tbl[3]  = '{1'b0, 4'h1, 1,  4'h1, 4'h1};   // edge 9: press pulse
    tbl[4]  = '{1'b0, 4'h1, 19, 4'h0, 4'h1};   // edges 10..28
    tbl[5]  = '{1'b0, 4'h1, 1,  4'h1, 4'h1};   // edge 29: first repeat
    tbl[6]  = '{1'b0, 4'h1, 4,  4'h0, 4'h1};
    tbl[7]  = '{1'b0, 4'h1, 1,  4'h1, 4'h1};   // edge 34
    tbl[8]  = '{1'b0, 4'h1, 4,  4'h0, 4'h1};
    tbl[9]  = '{1'b0, 4'h1, 1,  4'h1, 4'h1};   // edge 39
    tbl[10] = '{1'b0, 4'h0, 10, 4'h0, 4'h1};   // released from edge 40, still held
    tbl[11] = '{1'b0, 4'h0, 1,  4'h0, 4'h0};   // edge 50: level falls
    tbl[12] = '{1'b0, 4'h0, 5,  4'h0, 4'h0};

    for (int t = 0; t < 13; t++) begin
      reset   = tbl[t].rst;
      btn_raw = tbl[t].raw;
      for (int k = 0; k < tbl[t].cycles; k++) begin
        tick();
        check($sformatf("table%0d_pulse", t), pulse_a, tbl[t].exp_pulse);
        check($sformatf("table%0d_level", t), level_a, tbl[t].exp_level);
      end
    end

    // Bounce rejection on channel 1, then a stable press.
    for (int i = 0; i < 40; i++) begin
      btn_raw[1] = ((i / 3) % 2 == 0);
      tick();
      check("bounce_pulse", pulse_a[1], 1'b0);
      check("bounce_level", level_a[1], 1'b0);
    end
    btn_raw[1] = 1'b1;
    first = -1; na = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (pulse_a[1]) begin na++; if (first < 0) first = i; end
    end
    check("bounce_npulse", na, 1);
    check("bounce_at", first, 9);
    btn_raw[1] = 1'b0;
    repeat (14) tick();

    // Release glitch while repeating: channel returns to HELD, repeat delay restarts.
    btn_raw[0] = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("glitch_press", pulse_a[0], 1'b1);
    repeat (22) tick();
    btn_raw[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("glitch_low_pulse", pulse_a[0], 1'b0);
    end
    btn_raw[0] = 1'b1;
    for (int j = 0; j < 25; j++) begin
      tick();
      check("glitch_pulse", pulse_a[0], (j == 22));
      check("glitch_level", level_a[0], 1'b1);
    end
    btn_raw[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("release_pulse", pulse_a[0], 1'b0);
      check("release_level", level_a[0], (i < 10));
    end

    // Simultaneous press on channels 2 and 3.
    btn_raw = 4'b1100;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("simul_pulse", pulse_a, (i == 9) ? 4'b1100 : 4'b0000);
    end
    btn_raw = '0;
    repeat (14) tick();

    // Reset while channel 0 is repeating and still held.
    btn_raw[0] = 1'b1;
    repeat (35) tick();
    check("pre_rst_level", level_a[0], 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_pulse", pulse_a, 4'h0);
    check("rst_level", level_a, 4'h0);
    check("rst_pulse_norep", pulse_b, 4'h0);
    check("rst_level_norep", level_b, 4'h0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("rst_repress_pulse", pulse_a[0], (i == 9));
      check("rst_repress_level", level_a[0], (i >= 9));
    end
    btn_raw = '0;
    repeat (14) tick();

    // Long hold: auto-repeat build keeps stepping, no-repeat build pulses once.
    btn_raw[0] = 1'b1;
    na = 0; nb = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (pulse_a[0]) na++;
      if (pulse_b[0]) nb++;
      if (i >= 9) check("norep_level", level_b[0], 1'b1);
    end
    check("norep_npulse", nb, 1);
    check("rep_npulse", na, 36);
    btn_raw = '0;
    repeat (14) tick();

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NB; c++)
        if ($urandom_range(0, 24) == 0) btn_raw[c] = ~btn_raw[c];
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
